// File: rtl/nd_iterator_pkg.sv
// Shared types and default geometry for the N-dimensional loop iterator.
package nd_iterator_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int BW_DEFAULT  = 8;
    localparam int DIM_DEFAULT = 2;

endpackage

// File: rtl/nd_step.sv
// Combinational step of the iterator: per-dim add and wrap detect, carry chain
// from the innermost dim outward, one-hot wrap depth and next-coordinate mux.
module nd_step
    import nd_iterator_pkg::*;
#(
    parameter int BW          = BW_DEFAULT,
    parameter int DIM         = DIM_DEFAULT,
    parameter int UNIT_STRIDE = 0
) (
    input  logic [DIM-1:0][BW-1:0] cur_i,
    input  logic [DIM-1:0][BW-1:0] beg_i,
    input  logic [DIM-1:0][BW-1:0] stride_i,
    input  logic [DIM-1:0][BW-1:0] end_i,
    output logic [DIM-1:0][BW-1:0] nxt_o,
    output logic [DIM:0]           sel_ret_o
);

    logic          chain;
    logic [BW-1:0] step;
    logic [BW-1:0] sum;

    // NOTE: every variable gets a default before the loop so no path infers a latch.
    always_comb begin
        chain     = 1'b1;
        step      = '0;
        sum       = '0;
        nxt_o     = cur_i;
        sel_ret_o = '0;
        // k counts dims from the innermost; chain is true while all inner dims wrap.
        for (int k = 0; k < DIM; k++) begin
            step = (UNIT_STRIDE != 0) ? BW'(1) : stride_i[DIM-1-k];
            sum  = cur_i[DIM-1-k] + step;
            if (chain) begin
                nxt_o[DIM-1-k] = (sum == end_i[DIM-1-k]) ? beg_i[DIM-1-k] : sum;
            end
            sel_ret_o[k] = chain && (sum != end_i[DIM-1-k]);
            chain        = chain && (sum == end_i[DIM-1-k]);
        end
        sel_ret_o[DIM] = chain;
    end

endmodule

// File: rtl/nd_iterator.sv
// N-dimensional loop iterator: registers, IDLE/RUN FSM and src/dst handshakes.
// Optional coordinate counter output o_count enabled by ND_ITERATOR_COUNT_EN.
module nd_iterator
    import nd_iterator_pkg::*;
#(
    parameter int BW          = BW_DEFAULT,
    parameter int DIM         = DIM_DEFAULT,
    parameter int UNIT_STRIDE = 0
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   src_rdy,
    output logic                   src_ack,
    input  logic [DIM-1:0][BW-1:0] i_beg,
    input  logic [DIM-1:0][BW-1:0] i_stride,
    input  logic [DIM-1:0][BW-1:0] i_end,
    output logic                   dst_rdy,
    input  logic                   dst_ack,
    output logic [DIM-1:0][BW-1:0] o_id,
`ifdef ND_ITERATOR_COUNT_EN
    output logic [BW-1:0]          o_count,
`endif
    output logic [DIM:0]           o_sel_ret,
    output logic                   o_last
);

    state_e                 state_q, state_d;
    logic [DIM-1:0][BW-1:0] beg_q, beg_d;
    logic [DIM-1:0][BW-1:0] stride_q, stride_d;
    logic [DIM-1:0][BW-1:0] end_q, end_d;
    logic [DIM-1:0][BW-1:0] cur_q, cur_d;
    logic [DIM-1:0][BW-1:0] nxt_id;
    logic [DIM:0]           step_sel;
    logic                   run;
    logic                   xfer;
    logic                   zero_trip;

    nd_step #(
        .BW          (BW),
        .DIM         (DIM),
        .UNIT_STRIDE (UNIT_STRIDE)
    ) u_step (
        .cur_i     (cur_q),
        .beg_i     (beg_q),
        .stride_i  (stride_q),
        .end_i     (end_q),
        .nxt_o     (nxt_id),
        .sel_ret_o (step_sel)
    );

    // Outputs come from registers only; wrap info is masked outside RUN.
    assign run       = (state_q == RUN);
    assign dst_rdy   = run;
    assign o_id      = cur_q;
    assign o_sel_ret = run ? step_sel : '0;
    assign o_last    = o_sel_ret[DIM];
    assign xfer      = run & dst_ack;
    assign src_ack   = i_rst & src_rdy & (~run | (xfer & o_last));

    always_comb begin
        zero_trip = 1'b0;
        for (int d = 0; d < DIM; d++) begin
            if (i_beg[d] == i_end[d]) begin
                zero_trip = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        beg_d    = beg_q;
        stride_d = stride_q;
        end_d    = end_q;
        cur_d    = cur_q;
        if (src_ack) begin
            beg_d    = i_beg;
            stride_d = i_stride;
            end_d    = i_end;
            cur_d    = i_beg;
            state_d  = zero_trip ? IDLE : RUN;
        end else if (xfer) begin
            if (o_last) begin
                state_d = IDLE;
            end else begin
                cur_d = nxt_id;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= IDLE;
            beg_q    <= '0;
            stride_q <= '0;
            end_q    <= '0;
            cur_q    <= '0;
        end else begin
            state_q  <= state_d;
            beg_q    <= beg_d;
            stride_q <= stride_d;
            end_q    <= end_d;
            cur_q    <= cur_d;
        end
    end

`ifdef ND_ITERATOR_COUNT_EN
    logic [BW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (src_ack) begin
            count_d = '0;
        end else if (xfer && !o_last) begin
            count_d = count_q + BW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;
`endif

endmodule

// File: doc/nd_iterator.md
ND_ITERATOR -- requirements
Module: nd_iterator

Interface
REQ-001 SHALL have parameter BW, default 8, bit width of every coordinate.
REQ-002 SHALL have parameter DIM, default 2, number of loop dimensions (>=1); index 0 outermost, DIM-1 innermost.
REQ-003 SHALL have parameter UNIT_STRIDE, default 0; when 1, i_stride is ignored and every stride is 1.
REQ-004 i_clk  input  1  sole clock, all state on rising edge.
REQ-005 i_rst  input  1  asynchronous, active-low reset.
REQ-006 src_rdy  input  1  loop command valid.
REQ-007 src_ack  output  1  loop command accepted this cycle.
REQ-008 i_beg  input  BW x [DIM]  per-dim start.
REQ-009 i_stride  input  BW x [DIM]  per-dim increment.
REQ-010 i_end  input  BW x [DIM]  per-dim exclusive end.
REQ-011 dst_rdy  output  1  coordinate valid.
REQ-012 dst_ack  input  1  coordinate consumed.
REQ-013 o_id  output  BW x [DIM]  current coordinate.
REQ-014 o_sel_ret  output  DIM+1  one-hot wrap depth of the step after o_id; bit k set means the k innermost dims wrap; bit DIM means command end.
REQ-015 o_last  output  1  o_id is the final coordinate of the command (equals o_sel_ret[DIM]).

Function
REQ-016 SHALL implement FSM IDLE / RUN; src_ack = src_rdy & (IDLE | (RUN & dst_ack & o_last)).
REQ-017 On src_ack, beg/stride/end SHALL be latched into registers; cur <= beg; state <= RUN next cycle (or stays RUN when back-to-back).
REQ-018 dst_rdy SHALL be 1 exactly in RUN; o_id, o_sel_ret, o_last SHALL derive from registers only (no src-to-dst combinational path).
REQ-019 Latency: command accepted at cycle t yields first coordinate with dst_rdy at t+1.
REQ-020 On dst_rdy & dst_ack & !o_last: innermost dim advances cur+stride; dim wraps to beg when cur+stride == end and carries into the next outer dim; dims outside the carry chain hold.
REQ-021 On dst_rdy & dst_ack & o_last: state <= IDLE unless a new command is accepted the same cycle.
REQ-022 With dst_ack low, o_id, o_sel_ret, o_last SHALL hold stable.
REQ-023 Addition SHALL be modulo 2^BW; termination is equality only; a command whose end is unreachable from beg by stride is unsupported (no protection).
REQ-024 Zero-trip: if any dim has beg == end at acceptance, the command SHALL be consumed with no coordinate emitted, state stays/returns IDLE.
REQ-025 Total coordinates emitted per command SHALL be product over dims of (end-beg)/stride.

Reset
REQ-026 While i_rst low: state IDLE, src_ack 0, dst_rdy 0, o_id all 0, o_sel_ret 0, o_last 0, count 0.
REQ-027 Reset asserted mid-command SHALL abort it immediately; no coordinate of it is emitted after release.

Configuration
REQ-028 Macro ND_ITERATOR_COUNT_EN, when defined, SHALL add output o_count (BW bits): 0 on first coordinate of each command, +1 per accepted coordinate, wrapping modulo 2^BW.
REQ-029 Without ND_ITERATOR_COUNT_EN, port o_count and its register SHALL not exist; all other behaviour identical.

Structure
REQ-030 A shared package SHALL hold the FSM state enum (IDLE, RUN) and BW/DIM defaults.
REQ-031 Step logic (add, per-dim last detect, carry chain, one-hot o_sel_ret, next-coordinate mux) SHALL be one combinational sub-module nd_step; nd_iterator holds registers, FSM and handshake.

Verification
REQ-032 BW=8, DIM=2, beg={0,0}, stride={1,1}, end={2,3}, dst_ack always 1 -> o_id (0,0)(0,1)(0,2)(1,0)(1,1)(1,2); o_sel_ret 001,001,010,001,001,100; o_last only on (1,2).
REQ-033 Same command with dst_ack toggling 1-0 -> same sequence, each o_id held during ack-low cycles, 6 handshakes over 11 cycles.
REQ-034 beg={250,4}, stride={3,2}, end={3,8}, ack always 1 -> dim0 visits 250,253,0 (wrap mod 256); six coordinates; last (0,6).
REQ-035 Two commands back-to-back, src_rdy held -> second src_ack coincides with first command's last dst_ack; no idle cycle between; first o_id of command 2 next cycle.
REQ-036 Command with beg[1]==end[1]=5 -> src_ack 1, dst_rdy stays 0, state IDLE.
REQ-037 Assert i_rst during third coordinate of REQ-032 -> outputs zero asynchronously; after release dst_rdy 0 until a new command; with ND_ITERATOR_COUNT_EN, o_count 0,1,...,5 on REQ-032.
